cgra_sram_initiator: RTL and testbench

CGRA_SRAM_INITIATOR -- requirements
Module: cgra_sram_initiator

---
 rtl/cgra_sram_initiator.sv | 179 +++++++++++++++++
 tb/tb_cgra_sram_initiator.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_sram_initiator.sv
// Streams word-addressed command bursts between write/read stream ports and a single-port SRAM.
// Optional SRAM retention control is built when CGRA_SRAM_INITIATOR_RETENTION_EN is defined.
module cgra_sram_initiator #(
  parameter int unsigned NumWords      = 1024,
  parameter int unsigned AddrWidth     = (NumWords <= 1) ? 1 : $clog2(NumWords),
  parameter int unsigned RetIdleCycles = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_write_i,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [AddrWidth:0]   cmd_len_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic [31:0]          wr_data_i,
  input  logic [3:0]           wr_be_i,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic [31:0]          rd_data_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [31:0]          sram_wdata_o,
  output logic [3:0]           sram_be_o,
  input  logic [31:0]          sram_rdata_i,
  output logic                 sram_set_retentive_o,
  output logic                 busy_o,
  output logic                 done_o
);
  localparam int unsigned LenWidth = AddrWidth + 1;
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

  typedef enum logic [2:0] {StIdle, StWake, StWrite, StRead, StDone} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [LenWidth-1:0]  issue_left_q, issue_left_d;
  logic [LenWidth-1:0]  pop_left_q, pop_left_d;
  logic                 write_q, write_d;
  logic                 inflight_q, inflight_d;
  logic [1:0][31:0]     fifo_q, fifo_d;
  logic                 rptr_q, rptr_d, wptr_q, wptr_d;
  logic [1:0]           count_q, count_d;
  logic                 ret_active;
  logic                 accept, wr_fire, rd_issue, pop, fifo_pop, push;

  always_comb begin
    accept   = cmd_valid_i && (state_q == StIdle);
    wr_fire  = (state_q == StWrite) && wr_valid_i;
    rd_issue = (state_q == StRead) && (issue_left_q != '0) &&
               ((count_q + {1'b0, inflight_q}) < 2'd2);
    // Returning data bypasses an empty FIFO so a word is visible in the cycle it arrives.
    rd_valid_o = (count_q != 2'd0) || inflight_q;
    rd_data_o  = (count_q != 2'd0) ? fifo_q[rptr_q] : (inflight_q ? sram_rdata_i : 32'h0);
    pop        = rd_valid_o && rd_ready_i;
    fifo_pop   = pop && (count_q != 2'd0);
    push       = inflight_q && ((count_q != 2'd0) || !rd_ready_i);

    cmd_ready_o  = (state_q == StIdle);
    busy_o       = (state_q != StIdle);
    done_o       = (state_q == StDone);
    wr_ready_o   = (state_q == StWrite);
    sram_req_o   = wr_fire || rd_issue;
    sram_we_o    = wr_fire;
    sram_addr_o  = ((state_q == StWrite) || (state_q == StRead)) ? addr_q : '0;
    sram_wdata_o = (state_q == StWrite) ? wr_data_i : 32'h0;
    sram_be_o    = (state_q == StWrite) ? wr_be_i : (rd_issue ? 4'hF : 4'h0);
    sram_set_retentive_o = ret_active;
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    pop_left_d   = pop_left_q;
    write_d      = write_q;
    inflight_d   = rd_issue;
    fifo_d       = fifo_q;
    rptr_d       = rptr_q;
    wptr_d       = wptr_q;
    count_d      = count_q + {1'b0, push} - {1'b0, fifo_pop};

    if (sram_req_o) begin
      addr_d       = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
      issue_left_d = issue_left_q - 1'b1;
    end
    if (pop) pop_left_d = pop_left_q - 1'b1;
    if (push) begin
      fifo_d[wptr_q] = sram_rdata_i;
      wptr_d         = ~wptr_q;
    end
    if (fifo_pop) rptr_d = ~rptr_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d       = cmd_addr_i;
          issue_left_d = cmd_len_i;
          pop_left_d   = cmd_len_i;
          write_d      = cmd_write_i;
          if (cmd_len_i == '0)  state_d = StDone;
          else if (ret_active) state_d = StWake;
          else                 state_d = cmd_write_i ? StWrite : StRead;
        end
      end
      StWake:  state_d = write_q ? StWrite : StRead;
      StWrite: if (wr_fire && (issue_left_q == LenWidth'(1))) state_d = StDone;
      StRead:  if (pop && (pop_left_q == LenWidth'(1))) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      issue_left_q <= '0;
      pop_left_q   <= '0;
      write_q      <= 1'b0;
      inflight_q   <= 1'b0;
      fifo_q       <= '0;
      rptr_q       <= 1'b0;
      wptr_q       <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      pop_left_q   <= pop_left_d;
      write_q      <= write_d;
      inflight_q   <= inflight_d;
      fifo_q       <= fifo_d;
      rptr_q       <= rptr_d;
      wptr_q       <= wptr_d;
      count_q      <= count_d;
    end
  end

`ifdef CGRA_SRAM_INITIATOR_RETENTION_EN
  localparam int unsigned IdleWidth = (RetIdleCycles < 2) ? 1 : $clog2(RetIdleCycles);

  logic [IdleWidth-1:0] idle_cnt_q, idle_cnt_d;
  logic                 ret_q, ret_d;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    ret_d      = ret_q;
    if (accept) begin
      idle_cnt_d = '0;
      ret_d      = 1'b0;
    end else if (state_q != StIdle) begin
      idle_cnt_d = '0;
    end else if (!ret_q) begin
      if (idle_cnt_q == IdleWidth'(RetIdleCycles - 1)) ret_d = 1'b1;
      else idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_cnt_q <= '0;
      ret_q      <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      ret_q      <= ret_d;
    end
  end

  assign ret_active = ret_q;
`else
  logic unused_ret_idle;
  assign unused_ret_idle = ^RetIdleCycles;
  assign ret_active      = 1'b0;
`endif

endmodule

// File: tb/tb_cgra_sram_initiator.sv
// Directed bench for cgra_sram_initiator: command table with cycle-exact expectations plus
// hand-written sequences for rd_ready back-pressure, mid-read reset and retention wake-up.
module tb_cgra_sram_initiator;
  localparam int unsigned N  = 1024;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic          wr_valid = 1'b0, wr_ready;
  logic [31:0]   wr_data = '0;
  logic [3:0]    wr_be = '0;
  logic          rd_valid, rd_ready = 1'b1;
  logic [31:0]   rd_data;
  logic          sram_req, sram_we, sram_ret, busy, done_o;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata, sram_rdata;
  logic [3:0]    sram_be;

  int checks = 0;
  int errors = 0;

  logic [31:0] sram_mem [N];
  logic [31:0] ref_mem [N];

  typedef struct {
    bit          wr;
    int unsigned addr;
    int unsigned len;
    logic [3:0]  be;
  } vec_t;
  vec_t vecs [10];

  always #5 clk = ~clk;

  cgra_sram_initiator #(.NumWords(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data), .wr_be_i(wr_be),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata),
    .sram_set_retentive_o(sram_ret), .busy_o(busy), .done_o(done_o)
  );

  // SRAM model: byte-enabled write, read data one cycle after the request.
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_rd_data"}, rd_data, 32'd0);
    chk({tag, "_sram_req"}, 32'(sram_req), 32'd0);
    chk({tag, "_sram_we"}, 32'(sram_we), 32'd0);
    chk({tag, "_sram_addr"}, 32'(sram_addr), 32'd0);
    chk({tag, "_sram_wdata"}, sram_wdata, 32'd0);
    chk({tag, "_sram_be"}, 32'(sram_be), 32'd0);
    chk({tag, "_retentive"}, 32'(sram_ret), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit          pat [4];
    int unsigned issued, popped;
    bit          seen_done;

    for (int i = 0; i < N; i++) ref_mem[i] = 32'h0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    vecs[0] = '{1'b1, 5, 4, 4'hF};
    vecs[1] = '{1'b0, 5, 4, 4'hF};
    vecs[2] = '{1'b1, 1022, 4, 4'hF};
    vecs[3] = '{1'b0, 1022, 4, 4'hF};
    vecs[4] = '{1'b1, 7, 0, 4'hF};
    vecs[5] = '{1'b0, 9, 0, 4'hF};
    vecs[6] = '{1'b1, 6, 2, 4'h5};
    vecs[7] = '{1'b0, 5, 4, 4'hF};
    vecs[8] = '{1'b1, 100, 1026, 4'hF};
    vecs[9] = '{1'b0, 1022, 4, 4'hF};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_vals("reset");

    for (int v = 0; v < 10; v++) begin
      int unsigned a, len, done_c, idx;
      bit          exp_req, exp_valid;
      a      = vecs[v].addr;
      len    = vecs[v].len;
      done_c = (len == 0) ? 1 : (vecs[v].wr ? len + 1 : len + 2);
      for (int c = 0; c <= int'(done_c) + 1; c++) begin
        @(negedge clk);
        cmd_valid = (c == 0);
        cmd_write = vecs[v].wr;
        cmd_addr  = a[AW-1:0];
        cmd_len   = len[AW:0];
        wr_valid  = 1'b1;
        wr_data   = (32'(v) << 24) | (32'hA0 + 32'(c - 1));
        wr_be     = vecs[v].be;
        rd_ready  = 1'b1;
        #1;
        exp_req = (c >= 1) && (c <= int'(len));
        chk("sram_req", 32'(sram_req), 32'(exp_req));
        chk("done", 32'(done_o), 32'(c == int'(done_c)));
        chk("busy", 32'(busy), 32'((c >= 1) && (c <= int'(done_c))));
        if (c == 0 || c >= int'(done_c)) chk("idle_addr_zero", 32'(sram_addr), 32'd0);
        if (c == 0 || c == int'(done_c) + 1) chk("cmd_ready", 32'(cmd_ready), 32'd1);
        if (exp_req) begin
          idx = (a + 32'(c) - 1) % N;
          chk("sram_addr", 32'(sram_addr), idx);
          chk("sram_we", 32'(sram_we), 32'(vecs[v].wr));
          if (vecs[v].wr) begin
            chk("sram_wdata", sram_wdata, wr_data);
            chk("sram_be", 32'(sram_be), 32'(vecs[v].be));
            for (int b = 0; b < 4; b++) begin
              if (vecs[v].be[b]) ref_mem[idx][8*b +: 8] = wr_data[8*b +: 8];
            end
          end else begin
            chk("sram_be_rd", 32'(sram_be), 32'hF);
          end
        end
        if (!vecs[v].wr) begin
          exp_valid = (len != 0) && (c >= 2) && (c <= int'(len) + 1);
          chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
          if (exp_valid) chk("rd_data", rd_data, ref_mem[(a + 32'(c) - 2) % N]);
        end
      end
    end

    // Back-pressured read: nothing lost or duplicated, at most two words outstanding.
    issued    = 0;
    popped    = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      cmd_valid = (c == 0);
      cmd_write = 1'b0;
      cmd_addr  = 10'd200;
      cmd_len   = 11'd6;
      rd_ready  = pat[c % 4];
      #1;
      if (sram_req) issued++;
      if (rd_valid && rd_ready) begin
        chk("bp_rd_data", rd_data, ref_mem[200 + popped]);
        popped++;
      end
      chk("bp_outstanding_le2", 32'((issued - popped) <= 2), 32'd1);
      if (done_o) begin
        seen_done = 1'b1;
        break;
      end
    end
    chk("bp_done_seen", 32'(seen_done), 32'd1);
    chk("bp_popped", popped, 32'd6);
    chk("bp_issued", issued, 32'd6);

    // Reset in the middle of a read after three words have been popped.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      cmd_valid = (c == 0);
      cmd_write = 1'b0;
      cmd_addr  = 10'd300;
      cmd_len   = 11'd8;
      rd_ready  = 1'b1;
      #1;
      if (c >= 2) chk("rst_seq_rd_data", rd_data, ref_mem[300 + c - 2]);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_vals("mid_read_rst");
    @(negedge clk);
    #1;
    chk("post_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("post_rst_sram_req", 32'(sram_req), 32'd0);

`ifdef CGRA_SRAM_INITIATOR_RETENTION_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk("ret_after_idle", 32'(sram_ret), 32'(c == 16));
    end
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 10'd0;
    cmd_len   = 11'd1;
    wr_valid  = 1'b1;
    wr_be     = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("wake_ret_cleared", 32'(sram_ret), 32'd0);
    chk("wake_no_req", 32'(sram_req), 32'd0);
    chk("wake_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    chk("wake_then_req", 32'(sram_req), 32'd1);
    chk("wake_then_addr", 32'(sram_addr), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
